// File: rtl/alu_mul_sequencer_if.sv
// Bundles the EX-stage, multiply-request and ALU signals shared by the sequencer and its neighbours.
// No latency of its own: it only carries wires.
// Backpressure reaches the EX stage only through ex_stall. The ALU itself is purely combinational.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  // EX-stage request toward the ALU
  logic [WIDTH-1:0] ex_a;
  logic [WIDTH-1:0] ex_b;
  logic [1:0]       ex_sel;
  logic             ex_binvert;

  // Multiply request
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

  // Shared ALU
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic             alu_binvert;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  // Status and product
  logic             busy;
  logic             ex_stall;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  // Sequencer side: it owns the ALU operand mux and the product
  modport master (
    input  ex_a, ex_b, ex_sel, ex_binvert,
    input  start, mcand, mplier,
    input  alu_result, alu_cout,
    output alu_a, alu_b, alu_sel, alu_binvert,
    output busy, ex_stall, done, prod_hi, prod_lo
  );

  // Environment side: the EX stage, the requester and the ALU itself
  modport slave (
    output ex_a, ex_b, ex_sel, ex_binvert,
    output start, mcand, mplier,
    output alu_result, alu_cout,
    input  alu_a, alu_b, alu_sel, alu_binvert,
    input  busy, ex_stall, done, prod_hi, prod_lo
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Time-shares the ripple ALU between the EX stage and an unsigned shift-add multiplier.
// The product appears WIDTH+1 cycles after start is sampled: WIDTH CALC cycles, then a one-cycle DONE.
// While CALC is active it holds EX with ex_stall. A start outside IDLE is dropped, not queued.
module alu_mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst,
  alu_mul_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       SEL_ADD   = 2'b10;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [WIDTH-1:0]   mcand_reg, mcand_nxt;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH:0]     partial;   // carry-extended upper half for this iteration
  logic               busy_int;
  logic               done_int;

  // State and datapath registers. Reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      mcand_reg <= '0;
      prod      <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      mcand_reg <= mcand_nxt;
      prod      <= prod_nxt;
    end
  end

  // Next-state logic, ALU operand mux and shift-add step
  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    mcand_nxt       = mcand_reg;
    prod_nxt        = prod;
    partial         = '0;
    busy_int        = 1'b0;
    done_int        = 1'b0;
    bus.alu_a       = bus.ex_a;
    bus.alu_b       = bus.ex_b;
    bus.alu_sel     = bus.ex_sel;
    bus.alu_binvert = bus.ex_binvert;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt = bus.mcand;
          prod_nxt  = {{WIDTH{1'b0}}, bus.mplier};
          count_nxt = '0;
          state_nxt = CALC;
        end
      end

      CALC: begin
        busy_int        = 1'b1;
        bus.alu_a       = prod[2*WIDTH-1:WIDTH];
        bus.alu_b       = mcand_reg;
        bus.alu_sel     = SEL_ADD;
        bus.alu_binvert = 1'b0;
        // Keep the adder carry, so the (2W+1)-bit shift never loses a bit
        partial = prod[0] ? {bus.alu_cout, bus.alu_result}
                          : {1'b0, prod[2*WIDTH-1:WIDTH]};
        prod_nxt  = {partial, prod[WIDTH-1:1]};
        count_nxt = count + CNT_W'(1);
        if (count == LAST_ITER) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        done_int  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_int;
  assign bus.ex_stall = busy_int;
  assign bus.done     = done_int;
  assign bus.prod_hi  = prod[2*WIDTH-1:WIDTH];
  assign bus.prod_lo  = prod[WIDTH-1:0];

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer. It uses a behavioural ALU and checks against tables and a plain multiply model.
module tb_alu_mul_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ripple-ALU stand-in; carry-in tied to binvert
  logic [W:0]   add_full;
  logic [W-1:0] b_eff;
  always_comb begin
    b_eff        = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
    add_full     = {1'b0, bus.alu_a} + {1'b0, b_eff} + {{W{1'b0}}, bus.alu_binvert};
    bus.alu_cout = add_full[W];
    case (bus.alu_sel)
      2'b00:   bus.alu_result = bus.alu_a & b_eff;
      2'b01:   bus.alu_result = bus.alu_a | b_eff;
      2'b10:   bus.alu_result = add_full[W-1:0];
      default: bus.alu_result = {{(W-1){1'b0}}, add_full[W-1]};
    endcase
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sel;
    logic         binv;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic [1:0]   exp_sel;
    logic         exp_binv;
  } pt_vec_t;

  typedef struct {
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } mul_vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one multiply. It can inject a start pulse at busy cycle pulse_at and/or during DONE.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp, input int pulse_at, input bit pulse_done);
    int n;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mcand  = ~a;
    bus.mplier = ~b;
    chk("init_prod", {bus.prod_hi, bus.prod_lo}, {32'h0, b});
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      chk("stall_eq_busy", 64'(bus.ex_stall), 64'(1));
      chk("calc_sel", 64'(bus.alu_sel), 64'(2));
      chk("calc_binv", 64'(bus.alu_binvert), 64'(0));
      chk("calc_b_mcand", 64'(bus.alu_b), 64'(a));
      if (b == '0) chk("calc_a_zero", 64'(bus.alu_a), 64'(0));
      n++;
      bus.start = (n == pulse_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_cycles", 64'(n), 64'(W));
    chk("done_pulse", 64'(bus.done), 64'(1));
    chk("done_not_busy", 64'(bus.busy), 64'(0));
    chk("product", {bus.prod_hi, bus.prod_lo}, exp);
    bus.ex_a = 32'hA5A5_0F0F;
    bus.ex_sel = 2'b01;
    #1;
    chk("done_passthru_a", 64'(bus.alu_a), 64'(32'hA5A5_0F0F));
    chk("done_passthru_sel", 64'(bus.alu_sel), 64'(2'b01));
    if (pulse_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_once", 64'(bus.done), 64'(0));
    chk("idle_after_done", 64'(bus.busy), 64'(0));
    chk("prod_hold", {bus.prod_hi, bus.prod_lo}, exp);
    @(negedge clk);
    chk("still_idle", 64'(bus.busy), 64'(0));
    chk("prod_hold2", {bus.prod_hi, bus.prod_lo}, exp);
  endtask

  pt_vec_t  pt_tab[4];
  mul_vec_t mul_tab[6];

  initial begin
    pt_tab[0] = '{32'h0000_000C, 32'h0000_000A, 2'b10, 1'b1, 32'h0000_000C, 32'h0000_000A, 2'b10, 1'b1};
    pt_tab[1] = '{32'hFFFF_0000, 32'h1234_5678, 2'b00, 1'b0, 32'hFFFF_0000, 32'h1234_5678, 2'b00, 1'b0};
    pt_tab[2] = '{32'h0000_0001, 32'h8000_0000, 2'b01, 1'b0, 32'h0000_0001, 32'h8000_0000, 2'b01, 1'b0};
    pt_tab[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1};

    mul_tab[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    mul_tab[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    mul_tab[2] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    mul_tab[3] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    mul_tab[4] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    mul_tab[5] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000};

    rst            = 1'b1;
    bus.ex_a       = '0;
    bus.ex_b       = '0;
    bus.ex_sel     = 2'b00;
    bus.ex_binvert = 1'b0;
    bus.start      = 1'b0;
    bus.mcand      = '0;
    bus.mplier     = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_stall", 64'(bus.ex_stall), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_prod", {bus.prod_hi, bus.prod_lo}, 64'(0));
    rst = 1'b0;

    // IDLE pass-through table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ex_a       = pt_tab[i].a;
      bus.ex_b       = pt_tab[i].b;
      bus.ex_sel     = pt_tab[i].sel;
      bus.ex_binvert = pt_tab[i].binv;
      #1;
      chk("pt_a", 64'(bus.alu_a), 64'(pt_tab[i].exp_a));
      chk("pt_b", 64'(bus.alu_b), 64'(pt_tab[i].exp_b));
      chk("pt_sel", 64'(bus.alu_sel), 64'(pt_tab[i].exp_sel));
      chk("pt_binv", 64'(bus.alu_binvert), 64'(pt_tab[i].exp_binv));
      chk("pt_busy", 64'(bus.busy), 64'(0));
      chk("pt_done", 64'(bus.done), 64'(0));
    end

    // Directed multiply table
    for (int i = 0; i < 6; i++) begin
      run_mul(mul_tab[i].mcand, mul_tab[i].mplier,
              {mul_tab[i].exp_hi, mul_tab[i].exp_lo}, -1, 1'b0);
    end

    // A start during CALC and during DONE must be ignored
    run_mul(32'h0000_0009, 32'h0000_000B, 64'd99, 10, 1'b1);

    // Randomized operands against a plain 64-bit multiply
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'h0000_0001;
      run_mul(ra, rb, 64'(ra) * 64'(rb), -1, 1'b0);
    end

    // Reset in the middle of CALC aborts, then a fresh multiply works
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mcand  = 32'hDEAD_BEEF;
    bus.mplier = 32'h0001_2345;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    chk("mid_calc_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_prod", {bus.prod_hi, bus.prod_lo}, 64'(0));
    bus.ex_a   = 32'h0000_0055;
    bus.ex_sel = 2'b00;
    #1;
    chk("abort_passthru_a", 64'(bus.alu_a), 64'(32'h0000_0055));
    chk("abort_passthru_sel", 64'(bus.alu_sel), 64'(0));
    @(negedge clk);
    chk("abort_stays_idle", 64'(bus.busy), 64'(0));
    run_mul(32'h0000_0007, 32'h0000_0006, 64'd42, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
